// File: rtl/arith_mod_reduct_64bgoldilocks_pkg.sv
// Shared constants, types and helpers for the Goldilocks (p = 2^64 - 2^32 + 1)
// modular reduction pipeline.
package arith_mod_reduct_64bgoldilocks_pkg;

    localparam int MOD_W = 64;
    localparam int IN_W  = 98;

    localparam logic [MOD_W-1:0] GOLDILOCKS_P = 64'hFFFF_FFFF_0000_0001;

    typedef logic [MOD_W-1:0] residue_t;

    typedef enum logic [1:0] {
        SIDE_RST_NONE = 2'b00,
        SIDE_RST_ZERO = 2'b01,
        SIDE_RST_ONE  = 2'b10
    } side_rst_e;

    function automatic int get_latency(input int in_pipe);
        return in_pipe + 3;
    endfunction

    function automatic bit side_has_reset(input logic [1:0] rst_side);
        bit res;
        case (rst_side)
            SIDE_RST_ZERO: res = 1'b1;
            SIDE_RST_ONE:  res = 1'b1;
            default:       res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/arith_mod_reduct_64bgoldilocks_fold.sv
// One registered Goldilocks fold: x[63:0] + (x[IW-1:64] << 32) - x[IW-1:64],
// using 2^64 == 2^32 - 1 (mod p), with avail/side carried alongside.
module arith_mod_reduct_64bgoldilocks_fold
    import arith_mod_reduct_64bgoldilocks_pkg::*;
#(
    parameter int         IW       = 98,
    parameter int         OW       = 67,
    parameter int         SW       = 8,
    parameter logic [1:0] RST_SIDE = 2'b00
) (
    input  logic          clk,
    input  logic          s_rst_n,
    input  logic [IW-1:0] x,
    input  logic          in_avail,
    input  logic [SW-1:0] in_side,
    output logic [OW-1:0] y,
    output logic          out_avail,
    output logic [SW-1:0] out_side
);

    localparam int          HW           = IW - MOD_W;
    localparam bit          SIDE_RESET   = side_has_reset(RST_SIDE);
    localparam logic [SW-1:0] SIDE_RST_VAL = (RST_SIDE == SIDE_RST_ONE) ? {SW{1'b1}} : {SW{1'b0}};

    logic [HW-1:0] hi_s;
    logic [OW-1:0] sum_s;
    logic [OW-1:0] y_r;
    logic          avail_r;
    logic [SW-1:0] side_r;

    // (h << 32) >= h, so the subtraction never wraps within OW bits
    always_comb begin
        hi_s  = x[IW-1:MOD_W];
        sum_s = OW'(x[MOD_W-1:0]) + (OW'(hi_s) << 6'd32) - OW'(hi_s);
    end

    // stage valid bit, cleared by reset
    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            avail_r <= 1'b0;
        end else begin
            avail_r <= in_avail;
        end
    end

    // data register: loads only on a valid item, never reset
    always_ff @(posedge clk) begin
        if (in_avail) begin
            y_r <= sum_s;
        end
    end

    // side register: loads with the data, optional reset value
    always_ff @(posedge clk) begin
        if (!s_rst_n && SIDE_RESET) begin
            side_r <= SIDE_RST_VAL;
        end else if (in_avail) begin
            side_r <= in_side;
        end
    end

    assign y         = y_r;
    assign out_avail = avail_r;
    assign out_side  = side_r;

endmodule

// File: rtl/arith_mod_reduct_64bgoldilocks.sv
// Pipelined reduction of a 98-bit product to a canonical residue mod the
// Goldilocks prime: optional input register, two folds, final conditional subtract.
module arith_mod_reduct_64bgoldilocks
    import arith_mod_reduct_64bgoldilocks_pkg::*;
#(
    parameter int         SIDE_W   = 8,
    parameter logic [1:0] RST_SIDE = 2'b00,
    parameter int         IN_PIPE  = 1
) (
    input  logic                                      clk,
    input  logic                                      s_rst_n,
    input  logic [IN_W-1:0]                           a,
    input  logic                                      in_avail,
    input  logic [((SIDE_W > 0) ? SIDE_W : 1)-1:0]    in_side,
    output logic [MOD_W-1:0]                          z,
    output logic                                      out_avail,
    output logic [((SIDE_W > 0) ? SIDE_W : 1)-1:0]    out_side
);

    localparam int            SW           = (SIDE_W > 0) ? SIDE_W : 1;
    localparam int            F1_W         = 67;
    localparam int            F2_W         = 65;
    localparam bit            SIDE_RESET   = side_has_reset(RST_SIDE);
    localparam logic [SW-1:0] SIDE_RST_VAL = (RST_SIDE == SIDE_RST_ONE) ? {SW{1'b1}} : {SW{1'b0}};
    localparam logic [F2_W-1:0] P_EXT      = {1'b0, GOLDILOCKS_P};

    logic [IN_W-1:0]  f1_x_s;
    logic             f1_avail_s;
    logic [SW-1:0]    f1_side_s;

    logic [F1_W-1:0]  s1_s;
    logic             s1_avail_s;
    logic [SW-1:0]    s1_side_s;

    logic [F2_W-1:0]  s2_s;
    logic             s2_avail_s;
    logic [SW-1:0]    s2_side_s;

    logic [MOD_W-1:0] z_next_s;
    logic [MOD_W-1:0] z_r;
    logic             avail_r;
    logic [SW-1:0]    side_r;

    if (IN_PIPE != 0) begin : g_in_reg
        logic [IN_W-1:0] a_r;
        logic            in_avail_r;
        logic [SW-1:0]   in_side_r;

        // input valid bit, cleared by reset
        always_ff @(posedge clk) begin
            if (!s_rst_n) begin
                in_avail_r <= 1'b0;
            end else begin
                in_avail_r <= in_avail;
            end
        end

        // input data register, loads only on a valid item
        always_ff @(posedge clk) begin
            if (in_avail) begin
                a_r <= a;
            end
        end

        // input side register with optional reset value
        always_ff @(posedge clk) begin
            if (!s_rst_n && SIDE_RESET) begin
                in_side_r <= SIDE_RST_VAL;
            end else if (in_avail) begin
                in_side_r <= in_side;
            end
        end

        assign f1_x_s     = a_r;
        assign f1_avail_s = in_avail_r;
        assign f1_side_s  = in_side_r;
    end else begin : g_in_comb
        assign f1_x_s     = a;
        assign f1_avail_s = in_avail;
        assign f1_side_s  = in_side;
    end

    arith_mod_reduct_64bgoldilocks_fold #(
        .IW       (IN_W),
        .OW       (F1_W),
        .SW       (SW),
        .RST_SIDE (RST_SIDE)
    ) u_fold1 (
        .clk       (clk),
        .s_rst_n   (s_rst_n),
        .x         (f1_x_s),
        .in_avail  (f1_avail_s),
        .in_side   (f1_side_s),
        .y         (s1_s),
        .out_avail (s1_avail_s),
        .out_side  (s1_side_s)
    );

    // s1 < 2^67 leaves a 3-bit high part, so the second fold lands below 2p
    arith_mod_reduct_64bgoldilocks_fold #(
        .IW       (F1_W),
        .OW       (F2_W),
        .SW       (SW),
        .RST_SIDE (RST_SIDE)
    ) u_fold2 (
        .clk       (clk),
        .s_rst_n   (s_rst_n),
        .x         (s1_s),
        .in_avail  (s1_avail_s),
        .in_side   (s1_side_s),
        .y         (s2_s),
        .out_avail (s2_avail_s),
        .out_side  (s2_side_s)
    );

    // single conditional subtract suffices because s2 < 2p
    always_comb begin
        if (s2_s >= P_EXT) begin
            z_next_s = MOD_W'(s2_s - P_EXT);
        end else begin
            z_next_s = MOD_W'(s2_s);
        end
    end

    // output valid bit, cleared by reset
    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            avail_r <= 1'b0;
        end else begin
            avail_r <= s2_avail_s;
        end
    end

    // output residue, loads only on a valid item
    always_ff @(posedge clk) begin
        if (s2_avail_s) begin
            z_r <= z_next_s;
        end
    end

    // output side register with optional reset value
    always_ff @(posedge clk) begin
        if (!s_rst_n && SIDE_RESET) begin
            side_r <= SIDE_RST_VAL;
        end else if (s2_avail_s) begin
            side_r <= s2_side_s;
        end
    end

    assign z         = z_r;
    assign out_avail = avail_r;
    assign out_side  = side_r;

endmodule
